// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - shared encodings and width helpers for the Booth multiplier CU and datapath
package booth_pkg;

  localparam logic [2:0] ALU_NOP = 3'b000;
  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;

  localparam logic SHIFT_LEFT  = 1'b0;
  localparam logic SHIFT_RIGHT = 1'b1;

  // Accumulator must hold +/-2M for a WIDTH-bit signed M.
  function automatic int acc_width(input int w);
    return w + 2;
  endfunction

endpackage

// File: rtl/booth_alu.sv
// rtl/booth_alu.sv - combinational M/2M operand select and add/sub over the accumulator
module booth_alu
  import booth_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int AW    = acc_width(WIDTH)
) (
  input  logic [AW-1:0]    a,
  input  logic [WIDTH-1:0] m,
  input  logic             muxsel,
  input  logic [2:0]       aluop,
  output logic [AW-1:0]    result
);

  logic [AW-1:0] m_ext;
  logic [AW-1:0] b;

  always_comb begin
    m_ext = {{(AW-WIDTH){m[WIDTH-1]}}, m};
    b     = muxsel ? {m_ext[AW-2:0], 1'b0} : m_ext;
    case (aluop)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      default: result = a;
    endcase
  end

endmodule

// File: rtl/booth_datapath.sv
// rtl/booth_datapath.sv - Booth multiplier datapath: M/A/Q/Qm1 registers, shifter, iteration counter
module booth_datapath
  import booth_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int AW    = acc_width(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   mcand,
  input  logic [WIDTH-1:0]   mplier,
  input  logic               load,
  input  logic               muxsel,
  input  logic [2:0]         ALUop,
  input  logic               shift_direction,
  input  logic [2:0]         shift_amount,
  input  logic               out_enable,
  output logic [2:0]         cmp0,
  output logic [2:0]         cmp1,
  output logic [2*WIDTH-1:0] product,
  output logic               done
);

  localparam int RW = AW + WIDTH + 1;

  logic [WIDTH-1:0] m;
  logic [WIDTH-1:0] q;
  logic [AW-1:0]    a;
  logic             qm1;
  logic [2:0]       count;

  logic [AW-1:0]         a_alu;
  logic [1:0]            n_amt;
  logic [2:0]            n_ext;
  logic signed [RW-1:0]  r_in;
  logic signed [RW-1:0]  r_sr;
  logic [AW+WIDTH-1:0]   l_sh;
  logic [AW-1:0]         a_nxt;
  logic [WIDTH-1:0]      q_nxt;
  logic                  qm1_nxt;
  logic [2:0]            count_nxt;

  booth_alu #(
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_alu (
    .a      (a),
    .m      (m),
    .muxsel (muxsel),
    .aluop  (ALUop),
    .result (a_alu)
  );

  // The whole {A', Q, Qm1} chain shifts as one register, so Qm1 picks up the last bit out of Q[0].
  always_comb begin
    n_amt     = (shift_amount > 3'd2) ? 2'd2 : shift_amount[1:0];
    n_ext     = {1'b0, n_amt};
    r_in      = {a_alu, q, qm1};
    r_sr      = r_in >>> n_amt;
    l_sh      = {a_alu, q} << n_amt;
    a_nxt     = a_alu;
    q_nxt     = q;
    qm1_nxt   = qm1;
    count_nxt = count;
    if (n_amt != 2'd0) begin
      if (shift_direction == SHIFT_RIGHT) begin
        {a_nxt, q_nxt, qm1_nxt} = r_sr;
        count_nxt = (count > n_ext) ? (count - n_ext) : 3'd0;
      end else begin
        {a_nxt, q_nxt} = l_sh;
        qm1_nxt        = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m       <= '0;
      q       <= '0;
      a       <= '0;
      qm1     <= 1'b0;
      count   <= 3'd0;
      product <= '0;
      done    <= 1'b0;
    end else if (load) begin
      m     <= mcand;
      q     <= mplier;
      a     <= '0;
      qm1   <= 1'b0;
      count <= 3'(WIDTH);
      done  <= 1'b0;
    end else begin
      a     <= a_nxt;
      q     <= q_nxt;
      qm1   <= qm1_nxt;
      count <= count_nxt;
      if (out_enable) begin
        product <= {a[WIDTH-1:0], q};
      end
      done <= out_enable;
    end
  end

  assign cmp0 = {q[1], q[0], qm1};
  assign cmp1 = count;

endmodule
